// File: rtl/mem_lsu_pkg.sv
// Shared constants, FSM state encoding and opcode classifiers for the MEM-stage load/store unit.
// MEM_LSU_LLBIT_EN adds LL/SC to the set of memory operations.
package mem_lsu_pkg;

    localparam logic        RstEnable  = 1'b1;
    localparam logic        Stop       = 1'b1;
    localparam logic        NoStop     = 1'b0;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  RegNopAddr = 5'b00000;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
    localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    function automatic logic is_load_op(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load_op = 1'b1;
`ifdef MEM_LSU_LLBIT_EN
            EXE_LL_OP: is_load_op = 1'b1;
`endif
            default: is_load_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store_op = 1'b1;
`ifdef MEM_LSU_LLBIT_EN
            EXE_SC_OP: is_store_op = 1'b1;
`endif
            default: is_store_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Big-endian byte-lane steering: lane select, store replication, load extraction and alignment check.
// With MEM_LSU_LLBIT_EN, LL is handled as LW and SC as SW.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  i_aluop,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_reg2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_bsel;
    logic [3:0]  w_hsel;

    // Offset 00 is the most significant byte of the word.
    always_comb begin
        w_byte     = 8'h00;
        w_half     = 16'h0000;
        w_bsel     = 4'b0000;
        w_hsel     = 4'b0000;
        o_sel      = 4'b0000;
        o_wdata    = ZeroWord;
        o_ldata    = ZeroWord;
        o_misalign = 1'b0;

        case (i_offset)
            2'b00:   w_byte = i_rdata[31:24];
            2'b01:   w_byte = i_rdata[23:16];
            2'b10:   w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase

        if (i_offset[1]) begin
            w_half = i_rdata[15:0];
            w_hsel = 4'b0011;
        end else begin
            w_half = i_rdata[31:16];
            w_hsel = 4'b1100;
        end
        w_bsel = 4'b1000 >> i_offset;

        case (i_aluop)
            EXE_LB_OP: begin
                o_sel   = w_bsel;
                o_ldata = {{24{w_byte[7]}}, w_byte};
            end
            EXE_LBU_OP: begin
                o_sel   = w_bsel;
                o_ldata = {24'h00_0000, w_byte};
            end
            EXE_LH_OP: begin
                o_sel      = w_hsel;
                o_ldata    = {{16{w_half[15]}}, w_half};
                o_misalign = i_offset[0];
            end
            EXE_LHU_OP: begin
                o_sel      = w_hsel;
                o_ldata    = {16'h0000, w_half};
                o_misalign = i_offset[0];
            end
            EXE_SB_OP: begin
                o_sel   = w_bsel;
                o_wdata = {4{i_reg2[7:0]}};
            end
            EXE_SH_OP: begin
                o_sel      = w_hsel;
                o_wdata    = {2{i_reg2[15:0]}};
                o_misalign = i_offset[0];
            end
`ifdef MEM_LSU_LLBIT_EN
            EXE_LW_OP, EXE_LL_OP: begin
`else
            EXE_LW_OP: begin
`endif
                o_sel      = 4'b1111;
                o_ldata    = i_rdata;
                o_misalign = (i_offset != 2'b00);
            end
`ifdef MEM_LSU_LLBIT_EN
            EXE_SW_OP, EXE_SC_OP: begin
`else
            EXE_SW_OP: begin
`endif
                o_sel      = 4'b1111;
                o_wdata    = i_reg2;
                o_misalign = (i_offset != 2'b00);
            end
            default: begin
                o_sel      = 4'b0000;
                o_misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: pass-through for ALU ops, registered req/ack bus transaction for loads/stores.
// Optional MEM_LSU_LLBIT_EN adds the llbit register, the llbit_clr input and LL/SC support.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MEM_LSU_LLBIT_EN
    input  logic              llbit_clr,
`endif
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [31:0]       ex_wdata,
    input  logic              ex_whilo,
    input  logic [31:0]       ex_hi,
    input  logic [31:0]       ex_lo,
    input  logic [7:0]        ex_aluop,
    input  logic [31:0]       ex_mem_addr,
    input  logic [DATA_W-1:0] ex_reg2,
    output logic [4:0]        mem_wd,
    output logic              mem_wreg,
    output logic [31:0]       mem_wdata,
    output logic              mem_whilo,
    output logic [31:0]       mem_hi,
    output logic [31:0]       mem_lo,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_sel,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              mem_misalign,
    output logic              stallreq_mem
);

    lsu_state_e        r_state;
    lsu_state_e        w_next;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [3:0]        r_bus_sel;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [31:0]       r_ldata;

    logic [3:0]        w_sel;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ldata;
    logic              w_misalign;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_mem;
    logic              w_is_sc;
    logic              w_sc_fail;
    logic              w_start;

    mem_lsu_align u_align (
        .i_aluop    (ex_aluop),
        .i_offset   (ex_mem_addr[1:0]),
        .i_reg2     (ex_reg2),
        .i_rdata    (bus_rdata),
        .o_sel      (w_sel),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata),
        .o_misalign (w_misalign)
    );

    assign w_is_load  = is_load_op(ex_aluop);
    assign w_is_store = is_store_op(ex_aluop);
    assign w_is_mem   = w_is_load | w_is_store;

`ifdef MEM_LSU_LLBIT_EN
    logic r_llbit;

    assign w_is_sc   = (ex_aluop == EXE_SC_OP);
    assign w_sc_fail = w_is_sc & ~r_llbit;

    // Link bit: external clear wins over the LL set / SC clear issued from DONE.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_llbit <= 1'b0;
        end else if (llbit_clr) begin
            r_llbit <= 1'b0;
        end else if ((r_state == DONE) && (ex_aluop == EXE_LL_OP)) begin
            r_llbit <= 1'b1;
        end else if ((r_state == DONE) && w_is_sc) begin
            r_llbit <= 1'b0;
        end
    end
`else
    assign w_is_sc   = 1'b0;
    assign w_sc_fail = 1'b0;
`endif

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_sel   = r_bus_sel;
    assign bus_wdata = r_bus_wdata;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, stall request and the mem_* view handed to mem_wb.
    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        stallreq_mem = NoStop;
        mem_misalign = 1'b0;
        mem_wd       = ex_wd;
        mem_wreg     = ex_wreg;
        mem_wdata    = ex_wdata;
        mem_whilo    = ex_whilo;
        mem_hi       = ex_hi;
        mem_lo       = ex_lo;

        if (rst == RstEnable) begin
            w_next    = IDLE;
            mem_wd    = RegNopAddr;
            mem_wreg  = 1'b0;
            mem_wdata = ZeroWord;
            mem_whilo = 1'b0;
            mem_hi    = ZeroWord;
            mem_lo    = ZeroWord;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_is_mem) begin
                        w_next = IDLE;
                    end else if (w_misalign) begin
                        mem_misalign = 1'b1;
                        mem_wreg     = 1'b0;
                    end else if (w_sc_fail) begin
                        mem_wdata = ZeroWord;
                    end else begin
                        w_start      = 1'b1;
                        stallreq_mem = Stop;
                        mem_wreg     = 1'b0;
                        w_next       = BUSY;
                    end
                end
                BUSY: begin
                    stallreq_mem = Stop;
                    mem_wreg     = 1'b0;
                    if (bus_ack) begin
                        w_next = DONE;
                    end else begin
                        w_next = BUSY;
                    end
                end
                DONE: begin
                    // ex_* still holds the finished instruction, so it retires here exactly once.
                    w_next = IDLE;
                    if (w_is_load) begin
                        mem_wdata = r_ldata;
                    end else if (w_is_sc) begin
                        mem_wdata = 32'h0000_0001;
                    end else begin
                        mem_wreg = 1'b0;
                    end
                end
                default: begin
                    w_next   = IDLE;
                    mem_wreg = 1'b0;
                end
            endcase
        end
    end

    // Bus request registers and the load-data latch.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= {ADDR_W{1'b0}};
            r_bus_sel   <= 4'b0000;
            r_bus_wdata <= {DATA_W{1'b0}};
            r_ldata     <= ZeroWord;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= w_is_store;
                        r_bus_addr  <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
                        r_bus_sel   <= w_sel;
                        r_bus_wdata <= w_wdata;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_ldata   <= w_ldata;
                    end
                end
                default: begin
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
